// File: rtl/uart_tx_serializer.sv
// Purpose: serialises one byte per tx_dv into a UART frame (start, 8 data LSB-first, optional parity, 1-2 stop bits).
// Latency: start bit on the line the cycle after the accepting edge; tx_done pulses one cycle after the last stop bit.
// Backpressure: tx_dv is honoured only in IDLE; requests during a frame or CLEANUP are dropped, never queued.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_serial,
    output logic       tx_active,
    output logic       tx_done
);

    localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;

    logic          bit_end;
    logic          parity_bit;
    logic [2:0]    bit_idx_nxt;

    assign bit_end     = (clk_cnt_q == LAST_CLK);
    assign parity_bit  = (^byte_q) ^ (PARITY_ODD != 0);
    assign bit_idx_nxt = bit_idx_q + 3'd1;

    // Next-state logic; line/active/done are computed for the coming cycle so they leave as flops.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        byte_d     = byte_q;
        serial_d   = 1'b1;
        active_d   = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tx_dv) begin
                    byte_d    = tx_byte;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                end
            end
            S_START: begin
                active_d = 1'b1;
                serial_d = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                    serial_d  = byte_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                active_d = 1'b1;
                serial_d = byte_q[bit_idx_q];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = bit_idx_nxt;
                    if (bit_idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
                        if (PARITY_EN != 0) begin
                            state_d  = S_PARITY;
                            serial_d = parity_bit;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        serial_d = byte_q[bit_idx_nxt];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                active_d = 1'b1;
                serial_d = parity_bit;
                if (bit_end) begin
                    clk_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    state_d    = S_STOP;
                    serial_d   = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                active_d = 1'b1;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (stop_idx_q == LAST_STP) begin
                        state_d  = S_CLEANUP;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_CLEANUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the line idle-high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            byte_q     <= 8'h00;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            byte_q     <= byte_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances with different framing options at 4 clocks/bit.
// Instance 0 has its own request inputs; instances 1-3 share theirs.
// Every sampled cycle is compared with a frame model built from the bit-list definition of a UART frame.
module tb_uart_tx_serializer;

    localparam int C = 4;

    logic       clk;
    logic       reset;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;

    logic s0, s1, s2, s3;
    logic a0, a1, a2, a3;
    logic d0, d1, d2, d3;

    int checks;
    int errors;

    // inst 0: defaults; inst 1: odd parity; inst 2: even parity; inst 3: two stop bits
    uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .tx_dv(dv_a), .tx_byte(byte_a),
        .tx_serial(s0), .tx_active(a0), .tx_done(d0));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .tx_dv(dv_b), .tx_byte(byte_b),
        .tx_serial(s1), .tx_active(a1), .tx_done(d1));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .tx_dv(dv_b), .tx_byte(byte_b),
        .tx_serial(s2), .tx_active(a2), .tx_done(d2));
    uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .tx_dv(dv_b), .tx_byte(byte_b),
        .tx_serial(s3), .tx_active(a3), .tx_done(d3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {serial, active, done} for instance k, j cycles after the accepting edge.
    // j = 0 is the value visible right after that edge; any large j means idle.
    function automatic logic [2:0] exp_out(input int k, input int j, input logic [7:0] b);
        int pen, odd, stops, n, pos;
        logic [10:0] bits;
        pen   = (k == 1 || k == 2) ? 1 : 0;
        odd   = (k == 1) ? 1 : 0;
        stops = (k == 3) ? 2 : 1;
        n     = 1 + 8 + pen + stops;
        if (j < 0 || j > n * C) return 3'b100;
        if (j == n * C) return 3'b101;
        // frame as a plain bit list: start, data LSB first, [parity], stop(s)
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
        if (pen == 1) bits[9] = (^b) ^ (odd == 1);
        pos = j / C;
        return {bits[pos], 2'b10};
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input int ja, input logic [7:0] ba,
                             input int jb, input logic [7:0] bb);
        chk($sformatf("%s_i0_j%0d", tag, ja), {s0, a0, d0}, exp_out(0, ja, ba));
        chk($sformatf("%s_i1_j%0d", tag, jb), {s1, a1, d1}, exp_out(1, jb, bb));
        chk($sformatf("%s_i2_j%0d", tag, jb), {s2, a2, d2}, exp_out(2, jb, bb));
        chk($sformatf("%s_i3_j%0d", tag, jb), {s3, a3, d3}, exp_out(3, jb, bb));
    endtask

    // Advance one clock and check all instances just after the edge.
    task automatic step(input string tag, input int ja, input logic [7:0] ba,
                        input int jb, input logic [7:0] bb);
        @(posedge clk);
        #1;
        check_now(tag, ja, ba, jb, bb);
    endtask

    // One frame on every instance; tx_byte is scrambled mid-frame to prove it was latched.
    task automatic frame_all(input string tag, input logic [7:0] ba, input logic [7:0] bb);
        byte_a = ba; byte_b = bb; dv_a = 1'b1; dv_b = 1'b1;
        step(tag, 0, ba, 0, bb);
        dv_a = 1'b0; dv_b = 1'b0;
        for (int j = 1; j <= 47; j++) begin
            byte_a = 8'($urandom); byte_b = 8'($urandom);
            step(tag, j, ba, j, bb);
        end
    endtask

    initial begin
        logic [7:0] rb_a, rb_b;
        checks = 0; errors = 0;
        reset = 1'b0; dv_a = 1'b0; dv_b = 1'b0; byte_a = 8'h00; byte_b = 8'h00;

        // reset state
        #1 reset = 1'b1;
        #1 check_now("reset", 1000, 8'h00, 1000, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step("idle", 1000, 8'h00, 1000, 8'h00);

        // 0x35 on all: plain frame, odd parity=1, even parity=0, two stops
        frame_all("f35", 8'h35, 8'h35);
        // all-ones byte: two-stop instance holds low 4 then high 40
        frame_all("fFF", 8'hFF, 8'hFF);
        frame_all("f00", 8'h00, 8'h80);

        // randomized frames
        for (int r = 0; r < 6; r++) begin
            rb_a = 8'($urandom); rb_b = 8'($urandom);
            frame_all("rnd", rb_a, rb_b);
        end

        // stray requests during DATA and during CLEANUP are dropped
        byte_a = 8'h31; dv_a = 1'b1;
        step("drop", 0, 8'h31, 1000, 8'h00);
        dv_a = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            if (j == 10 || j == 41) begin dv_a = 1'b1; byte_a = 8'h00; end
            step("drop", j, 8'h31, 1000, 8'h00);
            dv_a = 1'b0;
        end

        // tx_dv held high: second frame accepted on the edge after CLEANUP (j=42)
        byte_a = 8'h30; dv_a = 1'b1;
        step("b2b", 0, 8'h30, 1000, 8'h00);
        byte_a = 8'h34;
        for (int j = 1; j <= 41; j++) step("b2b1", j, 8'h30, 1000, 8'h00);
        step("b2b2", 0, 8'h34, 1000, 8'h00);
        dv_a = 1'b0;
        for (int j = 1; j <= 44; j++) step("b2b2", j, 8'h34, 1000, 8'h00);

        // reset in the middle of data bit 3 (cycles 16..19)
        rb_a = 8'($urandom);
        byte_a = rb_a; dv_a = 1'b1;
        step("rst", 0, rb_a, 1000, 8'h00);
        dv_a = 1'b0;
        for (int j = 1; j <= 17; j++) step("rst", j, rb_a, 1000, 8'h00);
        #2 reset = 1'b1;
        #1 check_now("rst_async", 1000, rb_a, 1000, 8'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int j = 0; j < 30; j++) step("rst_nodone", 1000, rb_a, 1000, 8'h00);

        // normal operation after the abort
        rb_a = 8'($urandom); rb_b = 8'($urandom);
        frame_all("post", rb_a, rb_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
